// File: rtl/shift_sub_divider.sv
// shift_sub_divider
//
// Sequential restoring divider. It divides a 16-bit dividend by an 8-bit
// divisor and produces one quotient bit per clock. Operands are loaded with
// level-sensitive load strobes, and a rising edge on start launches a
// division. done stays high while the result is valid.
//
// Optional feature macro: DIV_BCD_EN
//   defined   : after the division, a double-dabble pass converts the
//               quotient to 5 BCD digits on q_BCD (32-cycle latency).
//   undefined : no converter; q_BCD is tied to zero (16-cycle latency).
//
// Ports:
//   clk_10kHz  in   1   system clock, rising edge
//   clrn       in   1   asynchronous active-low reset
//   a          in  16   dividend operand
//   b          in   8   divisor operand
//   load_a     in   1   capture a each clock while idle/done
//   load_b     in   1   capture b each clock while idle/done
//   start      in   1   rising edge starts a division
//   q          out 16   quotient
//   r          out  8   remainder
//   done       out  1   result valid
//   dz         out  1   last operation divided by zero
//   q_BCD      out 20   quotient in BCD (zero unless DIV_BCD_EN)

module shift_sub_divider (
  input  logic        clk_10kHz,
  input  logic        clrn,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  input  logic        load_a,
  input  logic        load_b,
  input  logic        start,
  output logic [15:0] q,
  output logic [7:0]  r,
  output logic        done,
  output logic        dz,
  output logic [19:0] q_BCD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
`ifdef DIV_BCD_EN
    BCD  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_reg_q, a_reg_d;
  logic [7:0]  b_reg_q, b_reg_d;
  // The partial remainder always fits in 8 bits after the restoring step.
  // The ninth bit exists only in the trial value used for the comparison.
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        start_prev_q, start_prev_d;
  logic [15:0] q_out_q, q_out_d;
  logic [7:0]  r_out_q, r_out_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;
`ifdef DIV_BCD_EN
  logic [19:0] bcd_acc_q, bcd_acc_d;
  logic [19:0] bcd_out_q, bcd_out_d;
  logic [19:0] bcd_adj;
`endif

  logic       start_edge;
  logic [8:0] trial;
  logic [8:0] diff;
  logic       ge;
  logic [8:0] rem_next;

  always_comb begin
    state_d      = state_q;
    a_reg_d      = a_reg_q;
    b_reg_d      = b_reg_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    start_prev_d = start;
    q_out_d      = q_out_q;
    r_out_d      = r_out_q;
    done_d       = done_q;
    dz_d         = dz_q;
`ifdef DIV_BCD_EN
    bcd_acc_d    = bcd_acc_q;
    bcd_out_d    = bcd_out_q;
    // Double-dabble correction: add 3 to every digit of 5 or more before
    // the shift.
    bcd_adj      = bcd_acc_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
      end
    end
`endif

    start_edge = start & ~start_prev_q;
    trial      = {rem_q, quo_q[15]};
    diff       = trial - {1'b0, b_reg_q};
    ge         = (trial >= {1'b0, b_reg_q});
    rem_next   = ge ? diff : trial;

    case (state_q)
      IDLE, DONE: begin
        // On a start edge, the operands already registered are used. A load
        // on that same edge is deliberately dropped.
        if (start_edge) begin
          state_d = CALC;
          quo_d   = a_reg_q;
          rem_d   = 8'd0;
          cnt_d   = 5'd0;
          done_d  = 1'b0;
          dz_d    = 1'b0;
        end else begin
          if (load_a) a_reg_d = a;
          if (load_b) b_reg_d = b;
        end
      end

      CALC: begin
        if (b_reg_q == 8'd0) begin
          state_d = DONE;
          q_out_d = 16'hFFFF;
          r_out_d = 8'd0;
          dz_d    = 1'b1;
          done_d  = 1'b1;
`ifdef DIV_BCD_EN
          bcd_out_d = 20'h0;
`endif
        end else begin
          quo_d = {quo_q[14:0], ge};
          rem_d = rem_next[7:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            q_out_d = {quo_q[14:0], ge};
            r_out_d = rem_next[7:0];
            cnt_d   = 5'd0;
`ifdef DIV_BCD_EN
            state_d   = BCD;
            bcd_acc_d = 20'h0;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef DIV_BCD_EN
      BCD: begin
        // The quotient left in quo_q is shifted out MSB first into the
        // BCD accumulator.
        bcd_acc_d = {bcd_adj[18:0], quo_q[15]};
        quo_d     = {quo_q[14:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bcd_out_d = {bcd_adj[18:0], quo_q[15]};
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // All state registers. Reset clears everything, so no partial result can
  // survive an abort.
  always_ff @(posedge clk_10kHz or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      a_reg_q      <= 16'd0;
      b_reg_q      <= 8'd0;
      rem_q        <= 8'd0;
      quo_q        <= 16'd0;
      cnt_q        <= 5'd0;
      start_prev_q <= 1'b0;
      q_out_q      <= 16'd0;
      r_out_q      <= 8'd0;
      done_q       <= 1'b0;
      dz_q         <= 1'b0;
`ifdef DIV_BCD_EN
      bcd_acc_q    <= 20'h0;
      bcd_out_q    <= 20'h0;
`endif
    end else begin
      state_q      <= state_d;
      a_reg_q      <= a_reg_d;
      b_reg_q      <= b_reg_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_prev_d;
      q_out_q      <= q_out_d;
      r_out_q      <= r_out_d;
      done_q       <= done_d;
      dz_q         <= dz_d;
`ifdef DIV_BCD_EN
      bcd_acc_q    <= bcd_acc_d;
      bcd_out_q    <= bcd_out_d;
`endif
    end
  end

  assign q    = q_out_q;
  assign r    = r_out_q;
  assign done = done_q;
  assign dz   = dz_q;
`ifdef DIV_BCD_EN
  assign q_BCD = bcd_out_q;
`else
  assign q_BCD = 20'h0;
`endif

endmodule
